// File: rtl/reg_bus_master.sv
// Initiator for the byte-enabled register bus. It turns one request at a time
// into per-register, per-byte write strobes or read enables, and it returns one
// response per request.
// Optional build macro WRITE_VERIFY_EN: every write is read back and compared
// on its enabled byte lanes. A mismatch sets rsp_err.
module reg_bus_master #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [1:0]            req_be,
    input  logic [15:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_data,
    output logic                  rsp_err,
    output logic [2*NUM_REGS-1:0] bus_wen,
    output logic [2*NUM_REGS-1:0] bus_ren,
    output logic [15:0]           bus_wdata,
    input  logic [15:0]           bus_rdata
);

    localparam int unsigned BUS_W     = 2 * NUM_REGS;
    localparam int unsigned ADDR_SPAN = 2 ** ADDR_W;
    // One bit per encodable address; the bit is set where a register exists.
    localparam logic [ADDR_SPAN-1:0] ADDR_OK = {ADDR_SPAN{1'b1}} >> (ADDR_SPAN - NUM_REGS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
`ifdef WRITE_VERIFY_EN
    localparam logic [2:0] S_VREAD   = 3'd5;
    localparam logic [2:0] S_VCHECK  = 3'd6;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        be_q, be_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rsp_data_d;
    logic              rsp_err_d;
    logic [15:0]       rdata_masked_c;
    logic [15:0]       lane_mask_c;
    logic [BUS_W-1:0]  lane_d;

    // Disabled byte lanes are forced to zero so that an undriven bus never leaks into the response.
    assign rdata_masked_c = {be_q[1] ? bus_rdata[15:8] : 8'h00,
                             be_q[0] ? bus_rdata[7:0]  : 8'h00};
    assign lane_mask_c    = {{8{be_q[1]}}, {8{be_q[0]}}};
    assign lane_d         = BUS_W'(be_d) << {addr_d, 1'b0};

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request latch and response value
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data;
        rsp_err_d  = rsp_err;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    be_d       = req_be;
                    wdata_d    = req_wdata;
                    rsp_data_d = 16'h0000;
                    rsp_err_d  = 1'b0;
                    if (!ADDR_OK[req_addr] || (req_be == 2'b00)) begin
                        rsp_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else if (req_write) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
`ifdef WRITE_VERIFY_EN
                state_d = S_VREAD;
`else
                state_d = S_RESP;
`endif
            end
            S_READ: begin
                rsp_data_d = rdata_masked_c;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_RESP;
            end
`ifdef WRITE_VERIFY_EN
            S_VREAD: begin
                rsp_data_d = rdata_masked_c;
                state_d    = S_VCHECK;
            end
            S_VCHECK: begin
                rsp_err_d = (rsp_data & lane_mask_c) != (wdata_q & lane_mask_c);
                state_d   = S_RESP;
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q    <= '0;
            be_q      <= 2'b00;
            wdata_q   <= 16'h0000;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 16'h0000;
            rsp_err   <= 1'b0;
            bus_wen   <= '0;
            bus_ren   <= '0;
            bus_wdata <= 16'h0000;
        end else begin
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            req_ready <= (state_d == S_IDLE);
            rsp_valid <= (state_d == S_RESP);
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            bus_wen   <= (state_d == S_WRITE) ? lane_d : '0;
`ifdef WRITE_VERIFY_EN
            bus_ren   <= ((state_d == S_READ) || (state_d == S_VREAD)) ? lane_d : '0;
`else
            bus_ren   <= (state_d == S_READ) ? lane_d : '0;
`endif
            if (state_d == S_WRITE) begin
                bus_wdata <= wdata_d;
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: register bank model on the tri-state read bus,
// write, read, error, backpressure and mid-read reset cases.
module tb_reg_bus_master;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned BUS_W    = 2 * NUM_REGS;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_be;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic [BUS_W-1:0]  bus_wen;
    logic [BUS_W-1:0]  bus_ren;
    logic [15:0]       bus_wdata;
    wire  [15:0]       bus_rdata;

    int total = 0;
    int bad   = 0;

    reg_bus_master #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    // Register bank model: byte writes on the rising edge, read enable latched on the falling edge.
    logic [15:0]      mem [NUM_REGS];
    logic [BUS_W-1:0] ren_lat = '0;
    logic             corrupt_hi = 1'b0;
    logic             drive_en;
    logic [15:0]      drive_val;

    always @(posedge clock) begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (bus_wen[2*i])   mem[i][7:0]  <= bus_wdata[7:0];
            if (bus_wen[2*i+1]) mem[i][15:8] <= bus_wdata[15:8];
        end
    end

    always @(negedge clock) ren_lat <= bus_ren;

    always_comb begin
        drive_en  = 1'b0;
        drive_val = 16'h0000;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (ren_lat[2*i +: 2] != 2'b00) begin
                drive_en  = 1'b1;
                drive_val = mem[i] ^ (corrupt_hi ? 16'h5A00 : 16'h0000);
            end
        end
    end

    assign bus_rdata = drive_en ? drive_val : 16'hzzzz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Per-transaction observations
    int               lat;
    logic [BUS_W-1:0] wen_or, ren_or;
    int               wen_cyc, ren_cyc, conflicts;

    task automatic sample;
        int regs_active;
        regs_active = 0;
        wen_or |= bus_wen;
        ren_or |= bus_ren;
        if (bus_wen != '0) wen_cyc++;
        if (bus_ren != '0) ren_cyc++;
        if ((bus_wen != '0) && (bus_ren != '0)) conflicts++;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if ((bus_wen[2*i +: 2] | bus_ren[2*i +: 2]) != 2'b00) regs_active++;
        end
        if (regs_active > 1) conflicts++;
    endtask

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [1:0] be, input logic [15:0] wd);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            tick;
            n++;
        end
        check("req_ready_at_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
        tick;
        req_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until rsp_valid shows.
    task automatic collect;
        lat = 1;
        wen_or = '0; ren_or = '0;
        wen_cyc = 0; ren_cyc = 0; conflicts = 0;
        sample;
        while (!rsp_valid && lat < 20) begin
            tick;
            lat++;
            sample;
        end
        if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input int exp_lat, input logic exp_err,
                              input logic [15:0] exp_data);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_conflicts"}, 32'(conflicts), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int        seen;
        logic [15:0] held;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_be = 2'b00; req_wdata = 16'h0000; rsp_ready = 1'b1;
        tick; tick;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wen", 32'(bus_wen), 32'd0);
        check("rst_ren", 32'(bus_ren), 32'd0);
        check("rst_wdata", 32'(bus_wdata), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        tick;

        // Write addr 2, both lanes
        issue(1'b1, 4'd2, 2'b11, 16'hBEEF);
        check("wr_wen", 32'(bus_wen), 32'h0030);
        check("wr_wdata", 32'(bus_wdata), 32'hBEEF);
        collect;
        check("wr_wen_cycles", 32'(wen_cyc), 32'd1);
        check("wr_wen_or", 32'(wen_or), 32'h0030);
`ifdef WRITE_VERIFY_EN
        expect_rsp("wr", 4, 1'b0, 16'hBEEF);
        check("wr_ren_or", 32'(ren_or), 32'h0030);
`else
        expect_rsp("wr", 2, 1'b0, 16'h0000);
        check("wr_ren_or", 32'(ren_or), 32'h0000);
`endif
        check("wr_req_ready_in_resp", 32'(req_ready), 32'd0);
        tick;
        check("wr_wdata_hold", 32'(bus_wdata), 32'hBEEF);

        // Read back addr 2, both lanes
        issue(1'b0, 4'd2, 2'b11, 16'h0000);
        collect;
        expect_rsp("rd2", 3, 1'b0, 16'hBEEF);
        tick;

        // Load addr 5 then read low lane only
        issue(1'b1, 4'd5, 2'b11, 16'hA55A);
        collect;
        tick;
        issue(1'b0, 4'd5, 2'b01, 16'h0000);
        check("rd5_ren", 32'(bus_ren), 32'h0400);
        collect;
        check("rd5_ren_cycles", 32'(ren_cyc), 32'd1);
        check("rd5_wen_or", 32'(wen_or), 32'h0000);
        expect_rsp("rd5", 3, 1'b0, 16'h005A);
        tick;

        // Error requests: out-of-range addresses and empty byte enables
        issue(1'b1, 4'd9, 2'b11, 16'h1111);
        collect;
        expect_rsp("err_a9", 1, 1'b1, 16'h0000);
        check("err_a9_strobes", 32'(wen_or | ren_or), 32'd0);
        tick;
        issue(1'b0, 4'd8, 2'b01, 16'h0000);
        collect;
        expect_rsp("err_a8", 1, 1'b1, 16'h0000);
        check("err_a8_strobes", 32'(wen_or | ren_or), 32'd0);
        tick;
        issue(1'b1, 4'd3, 2'b00, 16'h2222);
        collect;
        expect_rsp("err_be0", 1, 1'b1, 16'h0000);
        check("err_be0_strobes", 32'(wen_or | ren_or), 32'd0);
        tick;

        // Backpressure: high lane read of addr 5, then a queued write to addr 0
        rsp_ready = 1'b0;
        issue(1'b0, 4'd5, 2'b10, 16'h0000);
        collect;
        expect_rsp("bp", 3, 1'b0, 16'hA500);
        held = rsp_data;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd0; req_be = 2'b01; req_wdata = 16'h00C3;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("bp_valid_hold", 32'(rsp_valid), 32'd1);
            check("bp_data_hold", 32'(rsp_data), 32'(held));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_no_wen", 32'(bus_wen), 32'd0);
        end
        rsp_ready = 1'b1;
        tick;
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_ready", 32'(req_ready), 32'd1);
        check("bp_release_no_wen", 32'(bus_wen), 32'd0);
        tick;
        req_valid = 1'b0;
        check("bp_next_wen", 32'(bus_wen), 32'h0001);
        check("bp_next_wdata", 32'(bus_wdata), 32'h00C3);
        collect;
        tick;

        // Reset during READ
        issue(1'b0, 4'd5, 2'b11, 16'h0000);
        check("rst_mid_ren_before", 32'(bus_ren), 32'h0C00);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rst_mid_ren", 32'(bus_ren), 32'd0);
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (rsp_valid) seen++;
        end
        check("rst_mid_no_rsp", 32'(seen), 32'd0);

        // Write with corrupted high byte on readback
        corrupt_hi = 1'b1;
        issue(1'b1, 4'd6, 2'b11, 16'h1234);
        collect;
`ifdef WRITE_VERIFY_EN
        expect_rsp("vfy", 4, 1'b1, 16'h4834);
`else
        expect_rsp("vfy", 2, 1'b0, 16'h0000);
`endif
        tick;
        corrupt_hi = 1'b0;
        issue(1'b0, 4'd6, 2'b11, 16'h0000);
        collect;
        expect_rsp("rd6", 3, 1'b0, 16'h1234);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
